// File: rtl/proc_sequencer_if.sv
// Instruction-memory fetch channel between the sequencer (master) and imem (slave).
// req/addr are held stable until ack; ack is only meaningful while req is high.
interface proc_sequencer_if #(
  parameter int PC_WIDTH    = 4,
  parameter int INSTR_WIDTH = 12
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/proc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer with run/step/halt debug control.
// Optional BREAKPOINT_EN adds a PC breakpoint checked on WB->FETCH.
module proc_sequencer #(
  parameter int PC_WIDTH      = 4,
  parameter int INSTR_WIDTH   = 12,
  parameter int RESET_PC      = 0,
  parameter int FETCH_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step,
  proc_sequencer_if.master    imem,
`ifdef BREAKPOINT_EN
  input  logic                bp_valid,
  input  logic [PC_WIDTH-1:0] bp_addr,
  output logic                bp_hit,
`endif
  output logic [1:0]          rs1_addr,
  output logic [1:0]          rs2_addr,
  output logic [1:0]          rd_addr,
  output logic                alu_op,
  output logic                reg_we,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic                fault,
  output logic                retired,
  output logic [2:0]          state_dbg
);

  localparam int WCW = $clog2(FETCH_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t                 state;
  logic [INSTR_WIDTH-1:0] ir;
  logic                   step_mode;
  logic [WCW-1:0]         wait_cnt;
  logic [PC_WIDTH-1:0]    pc_next;
  logic [3:0]             opcode;
  logic                   is_add, is_sub, is_halt, in_exec;
  logic                   ir_unused;

  assign pc_next   = pc + PC_WIDTH'(1);
  assign opcode    = ir[11:8];
  assign is_add    = (opcode == 4'h0);
  assign is_sub    = (opcode == 4'h1);
  assign is_halt   = (opcode == 4'hF);
  assign ir_unused = ^ir[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_HALT;
      pc        <= PC_WIDTH'(RESET_PC);
      ir        <= '0;
      step_mode <= 1'b0;
      wait_cnt  <= '0;
`ifdef BREAKPOINT_EN
      bp_hit    <= 1'b0;
`endif
    end else begin
`ifdef BREAKPOINT_EN
      bp_hit <= 1'b0;
`endif
      case (state)
        S_HALT: begin
          if (run) begin
            state     <= S_FETCH;
            step_mode <= 1'b0;
          end else if (step) begin
            state     <= S_FETCH;
            step_mode <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem.imem_ack) begin
            ir       <= imem.imem_rdata;
            wait_cnt <= '0;
            state    <= S_DECODE;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
            if (wait_cnt == WCW'(FETCH_TIMEOUT - 1)) state <= S_FAULT;
          end
        end
        S_DECODE: begin
          // HALT retires here so the core parks without spending EXEC/WB cycles.
          if (is_halt) begin
            pc    <= pc_next;
            state <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: state <= S_WB;
        S_WB: begin
          pc <= pc_next;
          if (step_mode || !run) begin
            state <= S_HALT;
`ifdef BREAKPOINT_EN
          end else if (bp_valid && (pc_next == bp_addr)) begin
            state  <= S_HALT;
            bp_hit <= 1'b1;
`endif
          end else begin
            state <= S_FETCH;
          end
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_HALT;
      endcase
    end
  end

  // All outputs are pure decodes of state/IR/pc: no input-to-output paths.
  assign in_exec        = (state == S_DECODE) || (state == S_EXEC) || (state == S_WB);
  assign rs1_addr       = in_exec ? ir[3:2] : 2'b00;
  assign rs2_addr       = in_exec ? ir[5:4] : 2'b00;
  assign rd_addr        = in_exec ? ir[7:6] : 2'b00;
  assign alu_op         = in_exec && is_sub;
  assign reg_we         = (state == S_WB) && (is_add || is_sub);
  assign retired        = (state == S_WB) || ((state == S_DECODE) && is_halt);
  assign halted         = (state == S_HALT) || (state == S_FAULT);
  assign fault          = (state == S_FAULT);
  assign imem.imem_req  = (state == S_FETCH);
  assign imem.imem_addr = pc;
  assign state_dbg      = state;

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer: run, step, HALT opcode, fetch timeout, PC wrap, reset abort.
// Define BREAKPOINT_EN to also exercise the breakpoint scenario.
module tb_proc_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, step, ack_en;
  logic [1:0]  rs1_addr, rs2_addr, rd_addr;
  logic        alu_op, reg_we, halted, fault, retired;
  logic [3:0]  pc;
  logic [2:0]  state_dbg;
  logic [11:0] mem [16];
`ifdef BREAKPOINT_EN
  logic        bp_valid, bp_hit;
  logic [3:0]  bp_addr;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  proc_sequencer_if #(.PC_WIDTH(4), .INSTR_WIDTH(12)) imem_bus ();

  // Zero-wait instruction memory; ack_en=0 models a dead memory.
  assign imem_bus.imem_ack   = ack_en & imem_bus.imem_req;
  assign imem_bus.imem_rdata = mem[imem_bus.imem_addr];

  proc_sequencer #(.PC_WIDTH(4), .INSTR_WIDTH(12), .RESET_PC(0), .FETCH_TIMEOUT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .step      (step),
    .imem      (imem_bus.master),
`ifdef BREAKPOINT_EN
    .bp_valid  (bp_valid),
    .bp_addr   (bp_addr),
    .bp_hit    (bp_hit),
`endif
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rd_addr   (rd_addr),
    .alu_op    (alu_op),
    .reg_we    (reg_we),
    .pc        (pc),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired),
    .state_dbg (state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; run = 1'b0; step = 1'b0; ack_en = 1'b1;
`ifdef BREAKPOINT_EN
    bp_valid = 1'b0; bp_addr = 4'd0;
`endif
    for (int i = 0; i < 16; i++) mem[i] = 12'h200;
    mem[0] = 12'h040; mem[1] = 12'h040; mem[2] = 12'h040;
    mem[3] = 12'hF00; mem[5] = 12'h0C5;

    // Reset state
    tick(); tick();
    chk("rst_halted",  32'(halted), 1);
    chk("rst_pc",      32'(pc), 0);
    chk("rst_req",     32'(imem_bus.imem_req), 0);
    chk("rst_we",      32'(reg_we), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_fault",   32'(fault), 0);
    chk("rst_rd",      32'(rd_addr), 0);
    chk("rst_state",   32'(state_dbg), 0);

    // Continuous run over three ADDs: retire every 4th cycle
    reset = 1'b0; run = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("run_ret_c%0d", c), 32'(retired), 32'((c % 4) == 0));
      chk($sformatf("run_we_c%0d", c),  32'(reg_we),  32'((c % 4) == 0));
      chk($sformatf("run_pc_c%0d", c),  32'(pc),      32'((c - 1) / 4));
      chk($sformatf("run_rd_c%0d", c),  32'(rd_addr), 32'((c % 4) != 1));
      chk($sformatf("run_req_c%0d", c), 32'(imem_bus.imem_req), 32'((c % 4) == 1));
    end

    // HALT opcode at pc3
    tick();
    chk("hop_fetch_addr", 32'(imem_bus.imem_addr), 3);
    run = 1'b0;
    tick();
    chk("hop_dec_ret", 32'(retired), 1);
    chk("hop_dec_we",  32'(reg_we), 0);
    chk("hop_dec_hlt", 32'(halted), 0);
    tick();
    chk("hop_halted", 32'(halted), 1);
    chk("hop_pc",     32'(pc), 4);
    chk("hop_ret",    32'(retired), 0);

    // Single-cycle run pulse resumes at pc4 (NOP) and stops after it
    run = 1'b1;
    tick();
    chk("pulse_addr", 32'(imem_bus.imem_addr), 4);
    run = 1'b0;
    tick(); tick(); tick();
    chk("pulse_wb_ret", 32'(retired), 1);
    chk("pulse_wb_we",  32'(reg_we), 0);
    tick();
    chk("pulse_halted", 32'(halted), 1);
    chk("pulse_pc",     32'(pc), 5);

    // Single step at pc5: ADD rd=3 rs1=1
    step = 1'b1;
    tick();
    chk("step_req", 32'(imem_bus.imem_req), 1);
    step = 1'b0;
    tick();
    chk("step_rd",  32'(rd_addr), 3);
    chk("step_rs1", 32'(rs1_addr), 1);
    chk("step_rs2", 32'(rs2_addr), 0);
    tick();
    chk("step_exec_we", 32'(reg_we), 0);
    tick();
    chk("step_wb_we",  32'(reg_we), 1);
    chk("step_wb_ret", 32'(retired), 1);
    tick();
    chk("step_halted", 32'(halted), 1);
    chk("step_pc",     32'(pc), 6);
    tick(); tick();
    chk("step_no_refetch", 32'(imem_bus.imem_req), 0);
    chk("step_still_hlt",  32'(halted), 1);

    // run and step together: run wins, so the core keeps going past WB
    run = 1'b1; step = 1'b1;
    tick();
    step = 1'b0;
    tick(); tick(); tick();
    chk("rs_wb_ret", 32'(retired), 1);
    tick();
    chk("rs_refetch", 32'(imem_bus.imem_req), 1);
    chk("rs_addr",    32'(imem_bus.imem_addr), 7);
    // run drops mid-instruction: it completes then halts
    run = 1'b0;
    tick(); tick(); tick();
    chk("rfall_wb_ret", 32'(retired), 1);
    tick();
    chk("rfall_halted", 32'(halted), 1);
    chk("rfall_pc",     32'(pc), 8);

    // Fetch timeout: 8 FETCH cycles without ack, then FAULT
    ack_en = 1'b0; run = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("to_req_c%0d", c),   32'(imem_bus.imem_req), 1);
      chk($sformatf("to_fault_c%0d", c), 32'(fault), 0);
    end
    chk("to_addr", 32'(imem_bus.imem_addr), 8);
    tick();
    chk("to_fault",  32'(fault), 1);
    chk("to_halted", 32'(halted), 1);
    chk("to_req",    32'(imem_bus.imem_req), 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    ack_en = 1'b1;
    tick();
    chk("to_sticky", 32'(fault), 1);
    chk("to_noreq",  32'(imem_bus.imem_req), 0);
    chk("to_state",  32'(state_dbg), 5);
    reset = 1'b1;
    tick();
    reset = 1'b0; run = 1'b0;
    chk("to_rst_fault",  32'(fault), 0);
    chk("to_rst_pc",     32'(pc), 0);
    chk("to_rst_halted", 32'(halted), 1);

    // Run NOPs up to pc15, then SUB and PC wrap
    for (int i = 0; i < 16; i++) mem[i] = 12'h200;
    mem[15] = 12'h11A;
    run = 1'b1;
    n = 0;
    while (!(imem_bus.imem_req === 1'b1 && pc === 4'd15) && n < 200) begin
      tick();
      n++;
    end
    chk("wrap_reach_pc15", 32'(n < 200), 1);
    mem[0] = 12'h040;
    tick();
    chk("sub_dec_op",  32'(alu_op), 1);
    chk("sub_dec_rs1", 32'(rs1_addr), 2);
    chk("sub_dec_rs2", 32'(rs2_addr), 1);
    chk("sub_dec_we",  32'(reg_we), 0);
    tick();
    chk("sub_exec_op", 32'(alu_op), 1);
    chk("sub_exec_we", 32'(reg_we), 0);
    tick();
    chk("sub_wb_op",  32'(alu_op), 1);
    chk("sub_wb_we",  32'(reg_we), 1);
    chk("sub_wb_ret", 32'(retired), 1);
    tick();
    chk("wrap_pc",   32'(pc), 0);
    chk("wrap_addr", 32'(imem_bus.imem_addr), 0);
    tick(); tick();
    chk("abort_in_exec", 32'(state_dbg), 3);
    chk("abort_exec_we", 32'(reg_we), 0);
    reset = 1'b1;
    tick();
    chk("abort_halted", 32'(halted), 1);
    chk("abort_pc",     32'(pc), 0);
    chk("abort_we",     32'(reg_we), 0);
    reset = 1'b0; run = 1'b0;
    tick();
    chk("abort_we2",  32'(reg_we), 0);
    chk("abort_ret2", 32'(retired), 0);
    chk("abort_hlt2", 32'(halted), 1);

`ifdef BREAKPOINT_EN
    // Breakpoint at pc2: halts after pc1 WB, resume does not re-hit
    for (int i = 0; i < 16; i++) mem[i] = 12'h200;
    bp_valid = 1'b1; bp_addr = 4'd2; run = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("bp_run_hlt_c%0d", c), 32'(halted), 0);
      chk($sformatf("bp_run_hit_c%0d", c), 32'(bp_hit), 0);
    end
    tick();
    chk("bp_halted", 32'(halted), 1);
    chk("bp_pc",     32'(pc), 2);
    chk("bp_hit",    32'(bp_hit), 1);
    tick();
    chk("bp_resume_req", 32'(imem_bus.imem_req), 1);
    chk("bp_resume_adr", 32'(imem_bus.imem_addr), 2);
    chk("bp_hit_clear",  32'(bp_hit), 0);
    tick(); tick(); tick(); tick();
    chk("bp_next_addr", 32'(imem_bus.imem_addr), 3);
    chk("bp_no_rehit",  32'(halted), 0);
    run = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
